// File: rtl/host_wr_splitter.sv
// Burst-to-single-DW write splitter feeding the host-memory BFM.
// Flags the MSI-X doorbell write at the cycle its write handshake commits.
module host_wr_splitter #(
  parameter int                 ADDR_W    = 64,
  parameter int                 LEN_W     = 10,
  parameter logic [ADDR_W-1:0]  MSIX_ADDR = ADDR_W'(64'h0000_0000_0000_0001),
  parameter logic [31:0]        MSIX_DATA = 32'h1234_5678
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              dat_valid,
  output logic              dat_ready,
  input  logic [31:0]       dat_data,
  input  logic              dat_last,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              msix_intr,
  output logic              err_len,
  output logic              busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   cur_addr_r, cur_addr_s;
  logic [LEN_W-1:0]    cnt_r, cnt_s;
  logic                req_ready_r;
  logic                wr_valid_r, wr_valid_s;
  logic [ADDR_W-1:0]   wr_addr_r, wr_addr_s;
  logic [31:0]         wr_data_r, wr_data_s;
  logic                msix_r, msix_s;
  logic                err_r, err_s;
  logic                dat_ready_s;
  logic                beat_s;
  logic                wr_hs_s;
  logic                cnt_one_s;

  function automatic logic is_doorbell(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    return (a == MSIX_ADDR) && (d == MSIX_DATA);
  endfunction

  // The output register can take a new beat when empty or draining this cycle.
  assign dat_ready_s = (state_r == ST_BURST) && (!wr_valid_r || wr_ready);
  assign beat_s      = dat_valid && dat_ready_s;
  assign wr_hs_s     = wr_valid_r && wr_ready;
  assign cnt_one_s   = (cnt_r == LEN_W'(1));

  // Next-state, address/count and output-stage computation.
  always_comb begin
    state_s    = state_r;
    cur_addr_s = cur_addr_r;
    cnt_s      = cnt_r;
    wr_valid_s = wr_valid_r;
    wr_addr_s  = wr_addr_r;
    wr_data_s  = wr_data_r;
    msix_s     = 1'b0;
    err_s      = 1'b0;

    if (wr_hs_s) begin
      wr_valid_s = 1'b0;
      msix_s     = is_doorbell(wr_addr_r, wr_data_r);
    end else begin
      wr_valid_s = wr_valid_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready_r) begin
          cur_addr_s = req_addr;
          cnt_s      = req_len;
          if (req_len == LEN_W'(0)) begin
            err_s = 1'b1;
          end else begin
            state_s = ST_BURST;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (beat_s) begin
          // A beat loading in the drain cycle keeps wr_valid asserted.
          wr_valid_s = 1'b1;
          wr_addr_s  = cur_addr_r;
          wr_data_s  = dat_data;
          cur_addr_s = cur_addr_r + ADDR_W'(4);
          cnt_s      = cnt_r - LEN_W'(1);
          err_s      = (dat_last != cnt_one_s);
          if (dat_last || cnt_one_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_BURST;
          end
        end else begin
          state_s = ST_BURST;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any burst and pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cur_addr_r  <= '0;
      cnt_r       <= '0;
      req_ready_r <= 1'b0;
      wr_valid_r  <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= 32'h0000_0000;
      msix_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cur_addr_r  <= cur_addr_s;
      cnt_r       <= cnt_s;
      req_ready_r <= (state_s == ST_IDLE);
      wr_valid_r  <= wr_valid_s;
      wr_addr_r   <= wr_addr_s;
      wr_data_r   <= wr_data_s;
      msix_r      <= msix_s;
      err_r       <= err_s;
    end
  end

  assign req_ready = req_ready_r;
  assign dat_ready = dat_ready_s;
  assign wr_valid  = wr_valid_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign msix_intr = msix_r;
  assign err_len   = err_r;
  assign busy      = (state_r != ST_IDLE) || wr_valid_r;

endmodule

// File: tb/tb_host_wr_splitter.sv
// Directed self-checking bench for host_wr_splitter.
// Write handshakes and pulses are logged on the falling edge and compared to hand-computed values.
module tb_host_wr_splitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = 64'h0;
  logic [9:0]  req_len = 10'd0;
  logic        dat_valid = 1'b0;
  logic        dat_ready;
  logic [31:0] dat_data = 32'h0;
  logic        dat_last = 1'b0;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic        msix_intr;
  logic        err_len;
  logic        busy;

  host_wr_splitter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data), .dat_last(dat_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .msix_intr(msix_intr), .err_len(err_len), .busy(busy)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  int          err_cnt = 0;
  int          msix_cnt = 0;
  int          beat0_cyc = 0;
  logic [63:0] q_addr[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];
  logic [31:0] exp_data[8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // wr_ready source: always ready, or the 1,0,0 stall pattern.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        wr_ready = 1'b1;
        ph = 0;
      end else begin
        wr_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end
    end
  end

  // Falling-edge monitor: logs writes and pulses, and checks hold-while-stalled.
  initial begin
    logic        prev_stall = 1'b0;
    logic [63:0] prev_addr = 64'h0;
    logic [31:0] prev_data = 32'h0;
    forever begin
      @(negedge clk);
      if (wr_valid && wr_ready) begin
        q_addr.push_back(wr_addr);
        q_data.push_back(wr_data);
        q_cyc.push_back(cyc);
      end
      if (err_len) err_cnt++;
      if (msix_intr) msix_cnt++;
      if (prev_stall && !rst) begin
        chk("stall_valid", {63'h0, wr_valid}, 64'h1);
        chk("stall_addr", wr_addr, prev_addr);
        chk("stall_data", {32'h0, wr_data}, {32'h0, prev_data});
      end
      if (wr_valid && !wr_ready) chk("stall_dat_ready", {63'h0, dat_ready}, 64'h0);
      prev_stall = wr_valid && !wr_ready && !rst;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
    err_cnt = 0;
    msix_cnt = 0;
  endtask

  task automatic send_hdr(input logic [63:0] a, input logic [9:0] l);
    int n = 0;
    req_addr = a;
    req_len = l;
    req_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) chk("hdr_timeout", 64'h0, 64'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input bit first);
    int n = 0;
    dat_data = d;
    dat_last = last;
    dat_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!dat_ready && n < 50);
    if (!dat_ready) chk("beat_timeout", 64'h0, 64'h1);
    if (first) beat0_cyc = cyc;
    @(posedge clk);
    #1;
    dat_valid = 1'b0;
    dat_last = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_burst(input string tag, input logic [63:0] base, input int n, input int nerr);
    chk({tag, "_count"}, 64'(q_addr.size()), 64'(n));
    for (int i = 0; i < n && i < q_addr.size(); i++) begin
      chk({tag, "_addr"}, q_addr[i], base + 64'(4 * i));
      chk({tag, "_data"}, {32'h0, q_data[i]}, {32'h0, exp_data[i]});
    end
    chk({tag, "_err"}, 64'(err_cnt), 64'(nerr));
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {63'h0, req_ready}, 64'h0);
    chk("rst_dat_ready", {63'h0, dat_ready}, 64'h0);
    chk("rst_wr_valid", {63'h0, wr_valid}, 64'h0);
    chk("rst_wr_addr", wr_addr, 64'h0);
    chk("rst_wr_data", {32'h0, wr_data}, 64'h0);
    chk("rst_pulses", {62'h0, msix_intr, err_len}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: full-throughput burst, one write per cycle after each beat
    clear_log();
    for (int i = 0; i < 4; i++) exp_data[i] = 32'hA000_0000 + 32'(i);
    send_hdr(64'h1000, 10'd4);
    for (int i = 0; i < 4; i++) send_beat(exp_data[i], i == 3, i == 0);
    drain();
    check_burst("t1", 64'h1000, 4, 0);
    for (int i = 0; i < 4 && i < q_cyc.size(); i++)
      chk("t1_cycle", 64'(q_cyc[i]), 64'(beat0_cyc + 1 + i));
    chk("t1_idle_busy", {63'h0, busy}, 64'h0);

    // 2: same burst under back-pressure
    clear_log();
    for (int i = 0; i < 4; i++) exp_data[i] = 32'hB000_0000 + 32'(i);
    rdy_mode = 1;
    send_hdr(64'h1000, 10'd4);
    for (int i = 0; i < 4; i++) send_beat(exp_data[i], i == 3, i == 0);
    drain();
    rdy_mode = 0;
    drain();
    check_burst("t2", 64'h1000, 4, 0);

    // 3: MSI-X doorbell, then a near-miss on data
    clear_log();
    exp_data[0] = 32'h1234_5678;
    send_hdr(64'h1, 10'd1);
    send_beat(exp_data[0], 1'b1, 1'b1);
    drain();
    check_burst("t3a", 64'h1, 1, 0);
    chk("t3a_msix", 64'(msix_cnt), 64'h1);
    clear_log();
    exp_data[0] = 32'h1234_5679;
    send_hdr(64'h1, 10'd1);
    send_beat(exp_data[0], 1'b1, 1'b1);
    drain();
    check_burst("t3b", 64'h1, 1, 0);
    chk("t3b_msix", 64'(msix_cnt), 64'h0);

    // 4: early last, missing last, zero length
    clear_log();
    exp_data[0] = 32'hC000_0000;
    exp_data[1] = 32'hC000_0001;
    send_hdr(64'h4000, 10'd3);
    send_beat(exp_data[0], 1'b0, 1'b1);
    send_beat(exp_data[1], 1'b1, 1'b0);
    drain();
    check_burst("t4a", 64'h4000, 2, 1);
    chk("t4a_busy", {63'h0, busy}, 64'h0);
    clear_log();
    exp_data[0] = 32'hD000_0000;
    exp_data[1] = 32'hD000_0001;
    send_hdr(64'h5000, 10'd2);
    send_beat(exp_data[0], 1'b0, 1'b1);
    send_beat(exp_data[1], 1'b0, 1'b0);
    drain();
    check_burst("t4b", 64'h5000, 2, 1);
    clear_log();
    send_hdr(64'h6000, 10'd0);
    drain();
    check_burst("t4c", 64'h6000, 0, 1);
    chk("t4c_busy", {63'h0, busy}, 64'h0);

    // 5: address wraps through zero
    clear_log();
    for (int i = 0; i < 4; i++) exp_data[i] = 32'hE000_0000 + 32'(i);
    send_hdr(64'hFFFF_FFFF_FFFF_FFF8, 10'd4);
    for (int i = 0; i < 4; i++) send_beat(exp_data[i], i == 3, i == 0);
    drain();
    check_burst("t5", 64'hFFFF_FFFF_FFFF_FFF8, 4, 0);
    if (q_addr.size() > 2) chk("t5_wrap", q_addr[2], 64'h0);

    // 6: reset mid-burst with a pending write
    clear_log();
    send_hdr(64'h2000, 10'd8);
    for (int i = 0; i < 3; i++) send_beat(32'hF000_0000 + 32'(i), 1'b0, i == 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_pending", {63'h0, wr_valid}, 64'h1);
    @(negedge clk);
    chk("t6_rst_wr_valid", {63'h0, wr_valid}, 64'h0);
    chk("t6_rst_wr_addr", wr_addr, 64'h0);
    chk("t6_rst_wr_data", {32'h0, wr_data}, 64'h0);
    chk("t6_rst_ready", {62'h0, req_ready, dat_ready}, 64'h0);
    chk("t6_rst_misc", {61'h0, msix_intr, err_len, busy}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
    exp_data[0] = 32'h0BAD_CAFE;
    send_hdr(64'h3000, 10'd1);
    send_beat(exp_data[0], 1'b1, 1'b1);
    drain();
    check_burst("t6_after", 64'h3000, 1, 0);
    chk("t6_busy", {63'h0, busy}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
